cmac_tx_pkt_gen: RTL and testbench
==================================

# cmac_tx_pkt_gen

Frame generator that sources 512-bit AXI-Stream traffic into the CMAC TX interface (`m_axis_cmac_*`), taking the place of the host adapter path for link bring-up and loopback testing. It produces a configured number of fixed-length frames with a deterministic byte pattern, honours backpressure, and inserts a programmable idle gap between frames. Its frames are checked on the RX side by the companion checker.

## Interface
- `MIN_LEN`, default 64: minimum frame length in bytes; shorter requests are clamped up to this value.
- `MAX_LEN`, default 9600: maximum frame length in bytes; longer requests are clamped down to this value.
- `cmac_clk`  in  1  single clock for all logic.
- `rstn`  in  1  reset; synchronous, active-low.
- `start`  in  1  one-cycle request to begin a run; ignored while `busy`.
- `stop`  in  1  one-cycle request to end the run after the current frame completes.
- `cfg_len`  in  14  frame length in bytes; sampled on an accepted `start`.
- `cfg_count`  in  16  number of frames to send; 0 runs continuously until `stop`; sampled on an accepted `start`.
- `cfg_gap`  in  8  idle cycles between frames; sampled on an accepted `start`.
- `m_axis_cmac_tvalid`  out  1  AXIS valid.
- `m_axis_cmac_tdata`  out  512  AXIS data; byte 0 is `[7:0]`.
- `m_axis_cmac_tkeep`  out  64  AXIS byte enables.
- `m_axis_cmac_tlast`  out  1  marks the last beat of a frame.
- `m_axis_cmac_tuser_err`  out  1  frame error flag; always 0.
- `m_axis_cmac_tready`  in  1  AXIS ready from the CMAC.
- `busy`  out  1  high from an accepted `start` until the run ends.
- `done`  out  1  one-cycle pulse when a run ends.
- `tx_frames`  out  32  frames sent in the current run; wraps modulo 2^32.

## Operation
- **FSM states:** IDLE, SEND, GAP.
- **IDLE:**
  - `start` latches the three config inputs, clamps the length to [`MIN_LEN`, `MAX_LEN`], clears `tx_frames`, clears the sequence number `seq` to 0, and moves to SEND.
  - `stop` is ignored in IDLE.
- **Beat count:** beats = ceil(len/64).
  - Every beat except the last: `tkeep` = all ones.
  - Last beat: `tkeep` has the low (len mod 64) bits set, or all ones if len mod 64 = 0.
- **Data pattern:** byte i of beat b = (seq + 64·b + i) mod 256, computed in 8-bit arithmetic. Bytes not enabled by `tkeep` carry 0.
- **Beat handshake:** a beat transfers when `tvalid` and `tready` are both high. Only a transfer advances the beat counter.
- **End of frame:** on transfer of the `tlast` beat:
  - `tx_frames` and `seq` each increment by 1; `seq` is 8 bits and wraps.
  - If the run is complete (frames sent = `cfg_count` with `cfg_count` ≠ 0, or a `stop` is pending), go to IDLE and pulse `done`.
  - Otherwise, if `cfg_gap` = 0, stay in SEND and present the next frame's first beat in the following cycle, keeping `tvalid` continuously high.
  - Otherwise go to GAP.
- **GAP:** `tvalid` = 0 for exactly `cfg_gap` cycles, then return to SEND.
- **`stop` handling:** `stop` sets a pending flag in SEND or GAP.
  - Frames are never truncated.
  - If `stop` arrives in GAP, the generator ends immediately: go to IDLE and pulse `done`.
- **`start` while busy:** ignored; no effect on config or counters.

## Timing
- **Reset values:** all outputs are 0 at reset, including `tvalid`, `tdata`, `tkeep`, `tlast`, `busy`, `done` and `tx_frames`. FSM resets to IDLE.
- **Start latency:** `start` sampled at edge N gives `busy` = 1 and `tvalid` = 1 after edge N+1, i.e. one cycle of latency.
- **AXIS stability:** once `tvalid` is high, `tvalid`, `tdata`, `tkeep` and `tlast` hold constant until the transfer completes.
- **Throughput:** one beat per cycle while `tready` = 1.
- **Frame spacing:** the next frame's first beat is valid exactly `cfg_gap` + 1 cycles after the previous `tlast` transfer.
- **`done` timing:** `done` is high for the single cycle after the final `tlast` transfer (or after the cycle `stop` is seen in GAP). `busy` falls in that same cycle.
- **Simultaneous `stop` and `tlast` transfer:** the frame counts as sent and the run ends; no further frame starts.
- **Reset mid-frame:** `tvalid` drops at the next edge with `rstn` low; the partial frame is abandoned. This is the only permitted `tvalid` drop without a handshake.
- **Length clamping:** `cfg_len` = 0 sends 64 bytes; `cfg_len` = 16383 sends 9600 bytes (150 beats, last `tkeep` all ones).

## Test plan
- **Basic run:** len=64, count=1, gap=0, `tready`=1 → one beat; `tkeep`=all ones, `tlast`=1; byte i = i; `done` 2 cycles after `start`; `tx_frames`=1.
- **Partial last beat:** len=130, count=2, gap=0 → 3 beats per frame, 6 consecutive valid cycles; last-beat `tkeep`=0x3; frame 2 byte 0 = 0x01.
- **Gap spacing:** len=64, count=3, gap=5 → `tvalid` low exactly 5 cycles between frames; `done` after the third `tlast`.
- **Backpressure:** len=200 with `tready` toggling randomly (50%) → payload stable while stalled; beats in order; final `tkeep`=0xFF.
- **Continuous mode with stop:** count=0, len=100; `stop` asserted mid-frame 4 → frame 4 completes; `tx_frames`=4; `done` pulses once.
- **Clamping and reset:** len=10 → 64-byte frame. Separately, `rstn` low mid-frame → all outputs 0 next cycle; a new `start` restarts at `seq`=0.

Source files
------------

// File: rtl/cmac_tx_pkt_gen.sv
// Fixed-length AXI-Stream frame source for the CMAC TX port. Sends a configured
// number of frames carrying a rolling byte pattern, with a programmable idle gap.
module cmac_tx_pkt_gen #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 9600
) (
  input  logic         cmac_clk,
  input  logic         rstn,
  input  logic         start,
  input  logic         stop,
  input  logic [13:0]  cfg_len,
  input  logic [15:0]  cfg_count,
  input  logic [7:0]   cfg_gap,
  output logic         m_axis_cmac_tvalid,
  output logic [511:0] m_axis_cmac_tdata,
  output logic [63:0]  m_axis_cmac_tkeep,
  output logic         m_axis_cmac_tlast,
  output logic         m_axis_cmac_tuser_err,
  input  logic         m_axis_cmac_tready,
  output logic         busy,
  output logic         done,
  output logic [31:0]  tx_frames
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  last_beat_reg, last_beat_next;
  logic [63:0] last_keep_reg, last_keep_next;
  logic [15:0] count_reg, count_next;
  logic [7:0]  gap_reg, gap_next;
  logic [7:0]  gap_cnt_reg, gap_cnt_next;
  logic [7:0]  beat_reg, beat_next;
  logic [7:0]  seq_reg, seq_next;
  logic [31:0] tx_frames_reg, tx_frames_next;
  logic        stop_pend_reg, stop_pend_next;
  logic        done_reg, done_next;

  logic [13:0] len_clamped;
  logic [5:0]  len_rem;
  logic        is_last;
  logic        xfer;
  logic [31:0] frames_plus;
  logic        run_end;

  always_comb begin
    len_clamped = cfg_len;
    if (cfg_len < 14'(MIN_LEN)) begin
      len_clamped = 14'(MIN_LEN);
    end else if (cfg_len > 14'(MAX_LEN)) begin
      len_clamped = 14'(MAX_LEN);
    end
  end

  assign len_rem     = len_clamped[5:0];
  assign is_last     = (beat_reg == last_beat_reg);
  assign xfer        = m_axis_cmac_tvalid && m_axis_cmac_tready;
  assign frames_plus = tx_frames_reg + 32'd1;
  // A stop seen in the very cycle of the tlast transfer also ends the run.
  assign run_end     = stop_pend_reg || stop ||
                       ((count_reg != 16'd0) && (frames_plus == {16'd0, count_reg}));

  always_ff @(posedge cmac_clk) begin
    if (!rstn) begin
      state_reg     <= ST_IDLE;
      last_beat_reg <= 8'd0;
      last_keep_reg <= 64'd0;
      count_reg     <= 16'd0;
      gap_reg       <= 8'd0;
      gap_cnt_reg   <= 8'd0;
      beat_reg      <= 8'd0;
      seq_reg       <= 8'd0;
      tx_frames_reg <= 32'd0;
      stop_pend_reg <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      last_beat_reg <= last_beat_next;
      last_keep_reg <= last_keep_next;
      count_reg     <= count_next;
      gap_reg       <= gap_next;
      gap_cnt_reg   <= gap_cnt_next;
      beat_reg      <= beat_next;
      seq_reg       <= seq_next;
      tx_frames_reg <= tx_frames_next;
      stop_pend_reg <= stop_pend_next;
      done_reg      <= done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    last_beat_next = last_beat_reg;
    last_keep_next = last_keep_reg;
    count_next     = count_reg;
    gap_next       = gap_reg;
    gap_cnt_next   = gap_cnt_reg;
    beat_next      = beat_reg;
    seq_next       = seq_reg;
    tx_frames_next = tx_frames_reg;
    stop_pend_next = stop_pend_reg;
    done_next      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          count_next     = cfg_count;
          gap_next       = cfg_gap;
          last_beat_next = 8'((len_clamped - 14'd1) >> 6);
          last_keep_next = (len_rem == 6'd0) ? {64{1'b1}} : ~({64{1'b1}} << len_rem);
          tx_frames_next = 32'd0;
          seq_next       = 8'd0;
          beat_next      = 8'd0;
          stop_pend_next = 1'b0;
          state_next     = ST_SEND;
        end
      end

      ST_SEND: begin
        if (stop) begin
          stop_pend_next = 1'b1;
        end
        if (xfer) begin
          if (is_last) begin
            tx_frames_next = frames_plus;
            seq_next       = seq_reg + 8'd1;
            beat_next      = 8'd0;
            if (run_end) begin
              stop_pend_next = 1'b0;
              done_next      = 1'b1;
              state_next     = ST_IDLE;
            end else if (gap_reg != 8'd0) begin
              gap_cnt_next = gap_reg - 8'd1;
              state_next   = ST_GAP;
            end
          end else begin
            beat_next = beat_reg + 8'd1;
          end
        end
      end

      ST_GAP: begin
        // No frame is in flight during the gap, so a stop ends the run at once.
        if (stop || stop_pend_reg) begin
          stop_pend_next = 1'b0;
          done_next      = 1'b1;
          state_next     = ST_IDLE;
        end else if (gap_cnt_reg == 8'd0) begin
          state_next = ST_SEND;
        end else begin
          gap_cnt_next = gap_cnt_reg - 8'd1;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs derive only from registered state, so they hold steady during a stall.
  assign m_axis_cmac_tvalid    = (state_reg == ST_SEND);
  assign m_axis_cmac_tlast     = m_axis_cmac_tvalid && is_last;
  assign m_axis_cmac_tkeep     = !m_axis_cmac_tvalid ? 64'd0 :
                                 (is_last ? last_keep_reg : {64{1'b1}});
  assign m_axis_cmac_tuser_err = 1'b0;
  assign busy                  = (state_reg != ST_IDLE);
  assign done                  = done_reg;
  assign tx_frames             = tx_frames_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_byte
      logic [7:0] byte_val;
      assign byte_val = seq_reg + {beat_reg[1:0], 6'd0} + 8'(gi);
      assign m_axis_cmac_tdata[gi*8 +: 8] = m_axis_cmac_tkeep[gi] ? byte_val : 8'd0;
    end
  endgenerate

endmodule

// File: tb/tb_cmac_tx_pkt_gen.sv
// Bench for cmac_tx_pkt_gen: table of runs plus random runs checked against a
// byte-offset frame model, and hand-written stop-in-gap and reset sequences.
module tb_cmac_tx_pkt_gen;

  logic         cmac_clk = 1'b0;
  logic         rstn = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic [13:0]  cfg_len = 14'd0;
  logic [15:0]  cfg_count = 16'd0;
  logic [7:0]   cfg_gap = 8'd0;
  logic         tvalid;
  logic [511:0] tdata;
  logic [63:0]  tkeep;
  logic         tlast;
  logic         tuser_err;
  logic         tready = 1'b0;
  logic         busy;
  logic         done;
  logic [31:0]  tx_frames;

  int checks = 0;
  int errors = 0;

  always #5 cmac_clk = ~cmac_clk;

  cmac_tx_pkt_gen dut (
    .cmac_clk              (cmac_clk),
    .rstn                  (rstn),
    .start                 (start),
    .stop                  (stop),
    .cfg_len               (cfg_len),
    .cfg_count             (cfg_count),
    .cfg_gap               (cfg_gap),
    .m_axis_cmac_tvalid    (tvalid),
    .m_axis_cmac_tdata     (tdata),
    .m_axis_cmac_tkeep     (tkeep),
    .m_axis_cmac_tlast     (tlast),
    .m_axis_cmac_tuser_err (tuser_err),
    .m_axis_cmac_tready    (tready),
    .busy                  (busy),
    .done                  (done),
    .tx_frames             (tx_frames)
  );

  typedef struct {
    int          len;
    int          cnt;
    int          gap;
    int          rdy;
    int          stopf;
    int          frames;
    int          beats;
    logic [63:0] lkeep;
  } vec_t;

  vec_t vecs[11];

  task automatic chkv(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chkd(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int clamp_len(input int len);
    if (len < 64) return 64;
    if (len > 9600) return 9600;
    return len;
  endfunction

  // Expected beat content from the frame's byte offset: byte n of frame k is (k+n) mod 256.
  function automatic logic [511:0] exp_data(input int frame, input int off, input int L);
    logic [511:0] d;
    d = '0;
    for (int i = 0; i < 64; i++)
      if (off + i < L) d[i*8 +: 8] = 8'((frame + off + i) % 256);
    return d;
  endfunction

  function automatic logic [63:0] exp_keep(input int off, input int L);
    logic [63:0] k;
    k = '0;
    for (int i = 0; i < 64; i++)
      if (off + i < L) k[i] = 1'b1;
    return k;
  endfunction

  task automatic run(input int len, input int cnt, input int gap, input int rdy, input int stopf,
                     input int n_exp, input int beats_exp, input logic [63:0] lkeep_exp);
    int L, B, k, off, bif, since, cyc;
    bit fin, fin_xfer, stall, newf, stopped, tfchk, xfer;
    logic [511:0] s_data;
    logic [63:0]  s_keep;
    logic         s_last;
    L = clamp_len(len);
    B = (L + 63) / 64;
    k = 0; off = 0; bif = 0; since = 0; cyc = 0;
    fin = 0; fin_xfer = 0; stall = 0; newf = 0; stopped = 0; tfchk = 0;
    s_data = '0; s_keep = '0; s_last = 1'b0;
    @(negedge cmac_clk);
    cfg_len = 14'(len); cfg_count = 16'(cnt); cfg_gap = 8'(gap);
    start = 1'b1; tready = 1'b0;
    @(negedge cmac_clk);
    start = 1'b0;
    chkv("start_busy", 64'(busy), 64'd1);
    chkv("start_tvalid", 64'(tvalid), 64'd1);
    for (int it = 0; it < 5000 && !fin; it++) begin
      cyc++;
      if (tfchk) chkv("tx_frames_inc", 64'(tx_frames), 64'(k));
      tfchk = 0;
      if (fin_xfer) begin
        chkv("done_pulse", 64'(done), 64'd1);
        chkv("busy_fall", 64'(busy), 64'd0);
        chkv("frames_total", 64'(tx_frames), 64'(n_exp));
        if (rdy == 100 && stopf == 0)
          chkv("done_latency", 64'(cyc), 64'(n_exp * B + (n_exp - 1) * gap + 1));
        fin = 1;
      end else if (done) begin
        chkv("spurious_done", 64'(done), 64'd0);
        fin = 1;
      end else begin
        since++;
        if (stall) begin
          chkv("stall_valid", 64'(tvalid), 64'd1);
          chkd("stall_data", tdata, s_data);
          chkv("stall_keep_last", {tkeep[62:0], tlast}, {s_keep[62:0], s_last});
        end
        if (tvalid && newf) begin
          chkv("frame_spacing", 64'(since), 64'(gap + 1));
          newf = 0;
        end
        if (stopf != 0 && !stopped && tvalid && k == stopf - 1) begin
          stop = 1'b1;
          stopped = 1;
        end
        if (it == 2 && busy) begin
          start = 1'b1;
          cfg_len = 14'($urandom_range(0, 16383));
          cfg_count = 16'($urandom_range(1, 9));
          cfg_gap = 8'($urandom_range(0, 255));
        end
        tready = ($urandom_range(99) < rdy);
        xfer = tvalid && tready;
        stall = tvalid && !tready;
        s_data = tdata; s_keep = tkeep; s_last = tlast;
        if (xfer) begin
          chkd("beat_data", tdata, exp_data(k, off, L));
          chkv("beat_keep", tkeep, exp_keep(off, L));
          chkv("beat_last_err", {62'd0, tlast, tuser_err}, {62'd0, (off + 64 >= L), 1'b0});
          off += 64;
          bif++;
          if (off >= L) begin
            if (beats_exp != 0) begin
              chkv("table_beats", 64'(bif), 64'(beats_exp));
              chkv("table_last_keep", tkeep, lkeep_exp);
            end
            k++; off = 0; bif = 0; since = 0; tfchk = 1;
            if (k == n_exp) fin_xfer = 1;
            else newf = 1;
          end
        end
      end
      @(negedge cmac_clk);
      stop = 1'b0;
      start = 1'b0;
    end
    if (!fin) begin
      errors++;
      $display("FAIL run_timeout len=%0d frames_seen=%0d required=%0d", len, k, n_exp);
    end
    chkv("done_single", 64'(done), 64'd0);
    chkv("idle_tvalid", 64'(tvalid), 64'd0);
    $display("run len=%0d count=%0d gap=%0d rdy=%0d stop_at=%0d frames=%0d", len, cnt, gap, rdy,
             stopf, k);
    tready = 1'b0;
    repeat (2) @(negedge cmac_clk);
  endtask

  initial begin
    int rlen, rcnt, rgap, rrdy, rstopf, rn;
    vecs[0]  = '{len: 64,    cnt: 1,   gap: 0, rdy: 100, stopf: 0, frames: 1,   beats: 1,   lkeep: '1};
    vecs[1]  = '{len: 130,   cnt: 2,   gap: 0, rdy: 100, stopf: 0, frames: 2,   beats: 3,   lkeep: 64'h3};
    vecs[2]  = '{len: 64,    cnt: 3,   gap: 5, rdy: 100, stopf: 0, frames: 3,   beats: 1,   lkeep: '1};
    vecs[3]  = '{len: 200,   cnt: 2,   gap: 2, rdy: 50,  stopf: 0, frames: 2,   beats: 4,   lkeep: 64'hFF};
    vecs[4]  = '{len: 100,   cnt: 0,   gap: 1, rdy: 100, stopf: 4, frames: 4,   beats: 2,   lkeep: 64'hF_FFFF_FFFF};
    vecs[5]  = '{len: 10,    cnt: 1,   gap: 0, rdy: 100, stopf: 0, frames: 1,   beats: 1,   lkeep: '1};
    vecs[6]  = '{len: 0,     cnt: 1,   gap: 0, rdy: 100, stopf: 0, frames: 1,   beats: 1,   lkeep: '1};
    vecs[7]  = '{len: 16383, cnt: 1,   gap: 0, rdy: 100, stopf: 0, frames: 1,   beats: 150, lkeep: '1};
    vecs[8]  = '{len: 1000,  cnt: 3,   gap: 0, rdy: 70,  stopf: 0, frames: 3,   beats: 16,  lkeep: 64'hFF_FFFF_FFFF};
    vecs[9]  = '{len: 64,    cnt: 0,   gap: 0, rdy: 100, stopf: 3, frames: 3,   beats: 1,   lkeep: '1};
    vecs[10] = '{len: 64,    cnt: 300, gap: 0, rdy: 100, stopf: 0, frames: 300, beats: 1,   lkeep: '1};

    repeat (3) @(negedge cmac_clk);
    chkv("reset_tvalid", 64'(tvalid), 64'd0);
    chkd("reset_tdata", tdata, '0);
    chkv("reset_tkeep", tkeep, 64'd0);
    chkv("reset_ctl", {58'd0, tlast, tuser_err, busy, done, 2'b00}, 64'd0);
    chkv("reset_tx_frames", 64'(tx_frames), 64'd0);
    rstn = 1'b1;
    @(negedge cmac_clk);

    for (int v = 0; v < 11; v++)
      run(vecs[v].len, vecs[v].cnt, vecs[v].gap, vecs[v].rdy, vecs[v].stopf,
          vecs[v].frames, vecs[v].beats, vecs[v].lkeep);

    for (int r = 0; r < 6; r++) begin
      rlen = $urandom_range(0, 1300);
      rcnt = $urandom_range(0, 4);
      rgap = $urandom_range(0, 4);
      rrdy = $urandom_range(30, 100);
      rstopf = (rcnt == 0) ? $urandom_range(1, 3) : $urandom_range(0, 4);
      rn = (rcnt == 0) ? rstopf : ((rstopf != 0 && rstopf < rcnt) ? rstopf : rcnt);
      run(rlen, rcnt, rgap, rrdy, rstopf, rn, 0, '0);
    end

    // stop arriving during the gap ends the run immediately
    @(negedge cmac_clk);
    cfg_len = 14'd64; cfg_count = 16'd0; cfg_gap = 8'd6; start = 1'b1; tready = 1'b1;
    @(negedge cmac_clk);
    start = 1'b0;
    @(negedge cmac_clk);
    chkv("gap_idle", 64'(tvalid), 64'd0);
    chkv("gap_frames", 64'(tx_frames), 64'd1);
    @(negedge cmac_clk);
    stop = 1'b1;
    @(negedge cmac_clk);
    stop = 1'b0;
    chkv("gap_stop_done", {62'd0, done, busy}, {62'd0, 1'b1, 1'b0});
    chkv("gap_stop_frames", 64'(tx_frames), 64'd1);
    @(negedge cmac_clk);
    chkv("gap_stop_single", {62'd0, done, tvalid}, 64'd0);
    $display("run stop_in_gap frames=%0d", tx_frames);

    // reset mid-frame abandons the frame, a new start begins again at seq 0
    cfg_len = 14'd500; cfg_count = 16'd2; cfg_gap = 8'd0; start = 1'b1;
    @(negedge cmac_clk);
    start = 1'b0;
    repeat (3) @(negedge cmac_clk);
    chkv("pre_reset_tvalid", 64'(tvalid), 64'd1);
    rstn = 1'b0;
    @(negedge cmac_clk);
    chkv("midreset_tvalid", 64'(tvalid), 64'd0);
    chkd("midreset_tdata", tdata, '0);
    chkv("midreset_tkeep", tkeep, 64'd0);
    chkv("midreset_ctl", {60'd0, tlast, busy, done, tuser_err}, 64'd0);
    chkv("midreset_frames", 64'(tx_frames), 64'd0);
    rstn = 1'b1;
    @(negedge cmac_clk);
    cfg_len = 14'd64; cfg_count = 16'd1; start = 1'b1;
    @(negedge cmac_clk);
    start = 1'b0;
    chkv("restart_tvalid", 64'(tvalid), 64'd1);
    chkd("restart_seq0", tdata, exp_data(0, 0, 64));
    @(negedge cmac_clk);
    chkv("restart_done", {62'd0, done, busy}, {62'd0, 1'b1, 1'b0});
    chkv("restart_frames", 64'(tx_frames), 64'd1);
    $display("run reset_restart frames=%0d", tx_frames);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
